// File: rtl/bambu_mem_model_pkg.sv
// bambu_mem_model_pkg: shared constants, channel state type and size-to-mask helper
package bambu_mem_model_pkg;
  localparam int NCH    = 2;
  localparam int BYTE_W = 8;
  localparam int SIZE_W = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_ch_state_t;

  function automatic logic [BYTE_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
    return size >= SIZE_W'(BYTE_W) ? '1 : BYTE_W'((32'd1 << size) - 32'd1);
  endfunction
endpackage

// File: rtl/bambu_mem_channel_ctrl.sv
// bambu_mem_channel_ctrl: per-channel request FSM, latency counter, strobes and MEM_PROTOCOL_CHECK_EN checker
module bambu_mem_channel_ctrl
  import bambu_mem_model_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 4096,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1,
  parameter int unsigned OFF_W     = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       base_addr,
  input  logic              oe,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [SIZE_W-1:0] size,
  output logic [OFF_W-1:0]  off,
  output logic [BYTE_W-1:0] wr_mask,
  output logic [BYTE_W-1:0] wr_bits,
  output logic              rd_rdy,
  output logic              wr_en,
  output logic              protocol_err
);
  localparam int CNT_W = 4;
  mem_ch_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_x;
  logic             in_win, rd_req, wr_req, rd_done, wr_done;
  assign addr_x  = 32'(addr);
  assign in_win  = (addr_x >= base_addr) && ({1'b0, addr_x} < {1'b0, base_addr} + 33'(MEM_SIZE));
  assign off     = OFF_W'(addr_x - base_addr);
  assign wr_mask = size_to_mask(size);
  assign wr_bits = wdata & wr_mask;
  assign rd_req  = oe & ~we;
  assign wr_req  = we & ~oe;
  assign rd_done = state_q == RD_WAIT && rd_req && cnt_q == CNT_W'(READ_LAT - 1);
  // Single-cycle writes complete straight from IDLE and never visit WR_WAIT
  assign wr_done = WRITE_LAT == 1 ? state_q == IDLE && wr_req && in_win
                                  : state_q == WR_WAIT && wr_req && cnt_q == CNT_W'(WRITE_LAT - 1);
  assign rd_rdy  = rd_done & ~rst;
  assign wr_en   = wr_done & ~rst;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        state_d = rd_req && in_win ? RD_WAIT : wr_req && in_win && WRITE_LAT > 1 ? WR_WAIT : IDLE;
        cnt_d   = state_d == IDLE ? '0 : CNT_W'(1);
      end
      RD_WAIT: begin
        state_d = !rd_req || rd_done ? IDLE : RD_WAIT;
        cnt_d   = state_d == IDLE ? '0 : cnt_q + CNT_W'(1);
      end
      WR_WAIT: begin
        state_d = !wr_req || wr_done ? IDLE : WR_WAIT;
        cnt_d   = state_d == IDLE ? '0 : cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
`ifdef MEM_PROTOCOL_CHECK_EN
  logic              err_q, err_d, viol, busy;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [BYTE_W-1:0] wdata_q, wdata_d;
  // Request fields are snapshotted while idle and must hold steady until completion
  always_comb begin
    busy    = state_q != IDLE;
    viol    = (oe & we) | (state_q == RD_WAIT & ~oe) | (state_q == WR_WAIT & ~we)
            | (busy & (addr != addr_q || size != size_q)) | (state_q == WR_WAIT & wdata != wdata_q);
    err_d   = err_q | viol;
    addr_d  = busy ? addr_q : addr;
    size_d  = busy ? size_q : size;
    wdata_d = busy ? wdata_q : wdata;
  end
  always_ff @(posedge clk) begin
    err_q   <= rst ? 1'b0 : err_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end
  assign protocol_err = err_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk) if (!rst && viol && !err_q) $error("bambu_mem_channel_ctrl: protocol violation");
`endif
`else
  assign protocol_err = 1'b0;
`endif
endmodule

// File: rtl/bambu_offchip_mem_model.sv
// bambu_offchip_mem_model: dual-channel byte memory slave for HLS co-simulation; MEM_PROTOCOL_CHECK_EN enables the protocol checker
module bambu_offchip_mem_model
  import bambu_mem_model_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 4096,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             base_addr,
  input  logic [NCH-1:0]          Mout_oe_ram,
  input  logic [NCH-1:0]          Mout_we_ram,
  input  logic [NCH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [NCH*BYTE_W-1:0]   Mout_Wdata_ram,
  input  logic [NCH*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [NCH*BYTE_W-1:0]   M_Rdata_ram,
  output logic [NCH-1:0]          M_DataRdy,
  input  logic                    init_we,
  input  logic [ADDR_W-1:0]       init_addr,
  input  logic [BYTE_W-1:0]       init_data,
  input  logic [ADDR_W-1:0]       dump_addr,
  output logic [BYTE_W-1:0]       dump_data,
  output logic [NCH-1:0]          protocol_err
);
  localparam int unsigned OFF_W = $clog2(MEM_SIZE);
  logic [BYTE_W-1:0] mem_q [MEM_SIZE];
  logic [BYTE_W-1:0] rdata_q [NCH];
  logic [BYTE_W-1:0] rdata_d [NCH];
  logic [BYTE_W-1:0] wr_mask [NCH];
  logic [BYTE_W-1:0] wr_bits [NCH];
  logic [OFF_W-1:0]  off [NCH];
  logic [NCH-1:0]    rd_rdy, wr_en;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bambu_mem_channel_ctrl #(
      .MEM_SIZE (MEM_SIZE),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT),
      .WRITE_LAT(WRITE_LAT),
      .OFF_W    (OFF_W)
    ) u_ctrl (
      .clk         (clock),
      .rst         (reset),
      .base_addr   (base_addr),
      .oe          (Mout_oe_ram[c]),
      .we          (Mout_we_ram[c]),
      .addr        (Mout_addr_ram[ADDR_W*c +: ADDR_W]),
      .wdata       (Mout_Wdata_ram[BYTE_W*c +: BYTE_W]),
      .size        (Mout_data_ram_size[SIZE_W*c +: SIZE_W]),
      .off         (off[c]),
      .wr_mask     (wr_mask[c]),
      .wr_bits     (wr_bits[c]),
      .rd_rdy      (rd_rdy[c]),
      .wr_en       (wr_en[c]),
      .protocol_err(protocol_err[c])
    );
    assign rdata_d[c] = mem_q[off[c]];
    assign M_Rdata_ram[BYTE_W*c +: BYTE_W] = rd_rdy[c] ? rdata_q[c] : '0;
  end
  assign M_DataRdy = rd_rdy | wr_en;
  assign dump_data = mem_q[OFF_W'(dump_addr)];
  // Later assignments win on a shared offset: init over channel 1 over channel 0
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++)
      if (wr_en[i]) mem_q[off[i]] <= wr_bits[i] | (mem_q[off[i]] & ~wr_mask[i]);
    if (init_we) mem_q[OFF_W'(init_addr)] <= init_data;
  end
  always_ff @(posedge clock)
    for (int i = 0; i < NCH; i++) rdata_q[i] <= reset ? '0 : rdata_d[i];
endmodule

// File: tb/tb_bambu_offchip_mem_model.sv
// tb_bambu_offchip_mem_model: scoreboard bench with a byte-array reference model and randomized channel traffic
module tb_bambu_offchip_mem_model;
  localparam int RL = 2;
  localparam int WL = 1;
  localparam int AW = 12;
  localparam logic [31:0] BASE = 32'd512;
`ifdef MEM_PROTOCOL_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   base_addr = BASE;
  logic [1:0]    oe = '0, we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [15:0]   wdata = '0;
  logic [7:0]    size = '0;
  logic [15:0]   rdata;
  logic [1:0]    rdy, perr;
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0, dump_addr = '0;
  logic [7:0]    init_data = '0, dump_data;

  bambu_offchip_mem_model #(.MEM_SIZE(4096), .ADDR_W(AW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clock(clock), .reset(reset), .base_addr(base_addr),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
    .Mout_data_ram_size(size), .M_Rdata_ram(rdata), .M_DataRdy(rdy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .dump_addr(dump_addr), .dump_data(dump_data), .protocol_err(perr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {bit rd; logic [7:0] data; int cyc;} exp_t;
  exp_t q0[$], q1[$];
  logic [7:0] model [4096];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion strobe must match the oldest outstanding request of that channel
  always @(negedge clock)
    for (int c = 0; c < 2; c++)
      if (rdy[c]) begin
        if ((c == 0 ? q0.size() : q1.size()) == 0) check($sformatf("ch%0d_unexpected_rdy", c), 32'(rdy[c]), 0);
        else begin
          exp_t e;
          if (c == 0) e = q0.pop_front(); else e = q1.pop_front();
          check($sformatf("ch%0d_rdy_cycle", c), cyc, e.cyc);
          if (e.rd) check($sformatf("ch%0d_rdata", c), 32'(rdata[8*c +: 8]), 32'(e.data));
        end
      end

  task automatic access(input int c, input bit rd, input int off, input logic [7:0] wd, input logic [3:0] sz);
    exp_t e;
    int n;
    logic [7:0] m;
    @(posedge clock); #1;
    oe[c] = rd;
    we[c] = !rd;
    addr[AW*c +: AW] = AW'(BASE + 32'(off));
    wdata[8*c +: 8] = wd;
    size[4*c +: 4] = sz;
    m = sz >= 4'd8 ? 8'hFF : 8'((1 << sz) - 1);
    e.rd = rd;
    e.cyc = cyc + (rd ? RL : WL) - 1;
    e.data = model[off];
    if (!rd) model[off] = (wd & m) | (model[off] & ~m);
    if (c == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    do begin @(negedge clock); n++; end while (!rdy[c] && n < 20);
    if (!rdy[c]) check($sformatf("ch%0d_rdy_timeout", c), 32'(rdy[c]), 1);
  endtask

  task automatic idle(input int c);
    @(posedge clock); #1;
    oe[c] = 1'b0;
    we[c] = 1'b0;
  endtask

  task automatic init_byte(input int off, input logic [7:0] d);
    @(posedge clock); #1;
    init_we = 1'b1;
    init_addr = AW'(off);
    init_data = d;
    model[off] = d;
    @(posedge clock); #1;
    init_we = 1'b0;
  endtask

  task automatic dump_chk(input string name, input int off, input logic [7:0] exp);
    dump_addr = AW'(off);
    #1;
    check(name, 32'(dump_data), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) init_byte(i, 8'($urandom));
    init_byte(3, 8'h5A);
    init_byte(10, 8'hFF);
    @(negedge clock);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_perr", 32'(perr), 0);
    dump_chk("init_during_reset", 3, 8'h5A);
    @(posedge clock); #1;
    reset = 1'b0;

    access(0, 1, 3, 8'h00, 4'd8);
    idle(0);

    access(1, 0, 10, 8'h00, 4'd4);
    idle(1);
    dump_chk("masked_write", 10, 8'hF0);

    @(posedge clock); #1;
    oe[0] = 1'b1;
    addr[0 +: AW] = AW'(100);
    repeat (10) begin
      @(negedge clock);
      check("oow_rdy", 32'(rdy[0]), 0);
      check("oow_rdata", 32'(rdata[7:0]), 0);
    end
    idle(0);
    access(0, 1, 3, 8'h00, 4'd8);
    idle(0);

    fork
      begin access(0, 0, 7, 8'h11, 4'd8); idle(0); end
      begin access(1, 0, 7, 8'h22, 4'd8); idle(1); end
    join
    model[7] = 8'h22;
    dump_chk("ch_collision", 7, 8'h22);

    fork
      begin
        @(posedge clock); #1;
        init_we = 1'b1; init_addr = AW'(20); init_data = 8'h33;
        @(posedge clock); #1;
        init_we = 1'b0;
      end
      begin access(1, 0, 20, 8'h44, 4'd8); idle(1); end
    join
    model[20] = 8'h33;
    dump_chk("init_collision", 20, 8'h33);

    @(posedge clock); #1;
    oe[0] = 1'b1;
    addr[0 +: AW] = AW'(BASE + 3);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_rdwait_rdy", 32'(rdy), 0);
    @(posedge clock); #1;
    oe[0] = 1'b0;
    @(negedge clock);
    check("rst_after_rdy", 32'(rdy), 0);
    check("rst_after_rdata", 32'(rdata), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    access(0, 1, 3, 8'h00, 4'd8);
    access(0, 1, 10, 8'h00, 4'd8);
    idle(0);

    @(posedge clock); #1;
    oe[0] = 1'b1; we[0] = 1'b1;
    addr[0 +: AW] = AW'(BASE + 3);
    @(negedge clock);
    check("oe_we_no_rdy", 32'(rdy[0]), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("perr_set", 32'(perr[0]), 32'(PERR_EXP));
    @(posedge clock); #1;
    oe[0] = 1'b0; we[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("perr_sticky", 32'(perr[0]), 32'(PERR_EXP));
    @(posedge clock); #1;
    oe[0] = 1'b1;
    @(posedge clock); #1;
    oe[0] = 1'b0;
    @(negedge clock);
    check("abort_no_rdy", 32'(rdy[0]), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("perr_cleared", 32'(perr), 0);

    fork
      begin
        for (int i = 0; i < 150; i++) begin
          access(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 8'($urandom), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) idle(0);
        end
        idle(0);
      end
      begin
        for (int i = 0; i < 150; i++) begin
          access(1, 1'($urandom_range(0, 1)), int'($urandom_range(64, 127)), 8'($urandom), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
      end
    join
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 128; i++) dump_chk($sformatf("dump_sweep_%0d", i), i, model[i]);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
